neuron_acc_seq: RTL and testbench

Sequencer for the sign-magnitude summing datapath of a single neuron. It preloads a bias, accepts N_INPUTS signed-magnitude operands (weighted products) over a valid/ready stream, and folds them one per cycle into a running sum using sign-magnitude addition. It presents the final sum on a valid/ready output port. It sits between the multiplier stage and the activation stage of Simple_neuron.

---
 rtl/neuron_acc_seq_if.sv | 22 ++
 rtl/neuron_acc_seq.sv | 118 +++++++++++
 tb/tb_neuron_acc_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_acc_seq_if.sv
// Operand input stream and result output stream of the neuron accumulator.
// Both use a valid/ready handshake.
interface neuron_acc_seq_if #(
  parameter int DATA_W = 23
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_acc_seq.sv
// Sign-magnitude accumulator sequencer: it loads the bias, then folds in N_INPUTS
// streamed operands one per cycle, then offers the sum on the output stream.
module neuron_acc_seq #(
  parameter int DATA_W   = 23,
  parameter int N_INPUTS = 8,
  parameter int CNT_W    = 3,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              clear,
  neuron_acc_seq_if.slave   io,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              busy
);
  localparam int MAG_W = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_p1;
  logic [DATA_W-1:0] res_p2;
  logic [DATA_W-1:0] sum_p0;
  logic              add_ovf_p0;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  function automatic logic [DATA_W-1:0] normalise(input logic [DATA_W-1:0] x);
    if (x[MAG_W-1:0] == '0) return '0;
    return x;
  endfunction

  function automatic logic [MAG_W-1:0] clamp_mag(input logic [MAG_W:0] s);
    if (s[MAG_W] && (SATURATE != 0)) return '1;
    return s[MAG_W-1:0];
  endfunction

  // Returns {overflow, normalised sum}; overflow only arises on equal signs.
  function automatic logic [DATA_W:0] sm_add(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [MAG_W-1:0] ma, mb, mag;
    logic [MAG_W:0]   wide;
    logic             sgn, of;
    ma   = a[MAG_W-1:0];
    mb   = b[MAG_W-1:0];
    of   = 1'b0;
    wide = '0;
    if (a[DATA_W-1] == b[DATA_W-1]) begin
      wide = {1'b0, ma} + {1'b0, mb};
      of   = wide[MAG_W];
      mag  = clamp_mag(wide);
      sgn  = a[DATA_W-1];
    end else if (mb >= ma) begin
      mag = mb - ma;
      sgn = b[DATA_W-1];
    end else begin
      mag = ma - mb;
      sgn = a[DATA_W-1];
    end
    return {of, normalise({sgn, mag})};
  endfunction

  // Stage p0: combinational sign-magnitude add of accumulator and operand
  assign {add_ovf_p0, sum_p0} = sm_add(acc_p1, io.in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = ACCUM;
        ACCUM:   if (io.in_valid && (cnt_q == LAST)) state_d = DONE;
        DONE:    if (io.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p1/p2: accumulator, then the result register captured on the final transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      res_p2 <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      acc_p1 <= normalise(bias);
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if ((state_q == ACCUM) && io.in_valid) begin
      acc_p1 <= sum_p0;
      cnt_q  <= cnt_q + 1'b1;
      ovf_q  <= ovf_q | add_ovf_p0;
      if (cnt_q == LAST) res_p2 <= sum_p0;
    end
  end

  // count is CNT_W wide, so a completed evaluation reads N_INPUTS modulo 2^CNT_W
  assign count        = cnt_q;
  assign ovf          = ovf_q;
  assign busy         = (state_q != IDLE);
  assign io.in_ready  = (state_q == ACCUM);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = res_p2;
endmodule

// File: tb/tb_neuron_acc_seq.sv
// Bench for neuron_acc_seq: a saturating and a wrapping instance run the same
// stimulus and are compared against an integer-arithmetic reference model.
module tb_neuron_acc_seq;
  localparam int N     = 8;
  localparam int CNT_W = 3;
  localparam longint MAXM = (64'd1 << 22) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [22:0] bias = '0;
  logic [22:0] in_data = '0;
  logic [CNT_W-1:0] count_s, count_w, cnt_done;
  logic        ovf_s, ovf_w, busy_s, busy_w;
  int          errs = 0;
  int          checks = 0;

  neuron_acc_seq_if #(.DATA_W(23)) io_s ();
  neuron_acc_seq_if #(.DATA_W(23)) io_w ();

  assign io_s.in_valid  = in_valid;
  assign io_s.in_data   = in_data;
  assign io_s.out_ready = out_ready;
  assign io_w.in_valid  = in_valid;
  assign io_w.in_data   = in_data;
  assign io_w.out_ready = out_ready;

  neuron_acc_seq #(.DATA_W(23), .N_INPUTS(N), .CNT_W(CNT_W), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .clear(clear),
    .io(io_s.slave), .count(count_s), .ovf(ovf_s), .busy(busy_s));

  neuron_acc_seq #(.DATA_W(23), .N_INPUTS(N), .CNT_W(CNT_W), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .clear(clear),
    .io(io_w.slave), .count(count_w), .ovf(ovf_w), .busy(busy_w));

  always #5 clk = ~clk;

  function automatic longint smv(input logic [22:0] x);
    longint m;
    m = longint'(x[21:0]);
    return x[22] ? -m : m;
  endfunction

  // Reference: plain signed integer sum, clamped or wrapped whenever it leaves the range
  function automatic void model(input logic [22:0] b, input logic [22:0] ops [N],
                                input bit sat, output logic [22:0] res, output bit of);
    longint v, m;
    v  = smv(b);
    of = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = v + smv(ops[i]);
      if (v > MAXM || v < -MAXM) begin
        of = 1'b1;
        m  = (v < 0) ? -v : v;
        m  = sat ? MAXM : (m % (MAXM + 1));
        v  = (v < 0) ? -m : m;
      end
    end
    m   = (v < 0) ? -v : v;
    res = {(v < 0), m[21:0]};
  endfunction

  task automatic drive_eval(input logic [22:0] b, input logic [22:0] ops [N],
                            input int gap_pct, input bit noise,
                            output int first_valid, output bit to);
    int idx, cyc;
    bias = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; idx = 0; first_valid = 0; to = 1'b0;
    while (idx < N) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? ops[idx] : 23'($urandom);
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        bias  = 23'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (in_valid) idx++;
      if (io_s.out_valid && first_valid == 0) first_valid = cyc;
      if (cyc > 400) begin to = 1'b1; break; end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({io_s.out_data, io_w.out_data} !== '0) begin errs++; $display("FAIL reset_out_data: got %h/%h want 0", io_s.out_data, io_w.out_data); end
    checks++; if ({count_s, ovf_s, busy_s, io_s.in_ready, io_s.out_valid} !== '0) begin errs++; $display("FAIL reset_ctrl: got cnt=%0d ovf=%b busy=%b ir=%b ov=%b want all 0", count_s, ovf_s, busy_s, io_s.in_ready, io_s.out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum();
    logic [22:0] ops [N];
    int fv; bit to;
    for (int i = 0; i < N; i++) ops[i] = 23'(i + 1);
    drive_eval(23'd5, ops, 0, 1'b0, fv, to);
    checks++; if (to) begin errs++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++; if (fv !== 9) begin errs++; $display("FAIL basic_latency: got %0d want 9", fv); end
    checks++; if (io_s.out_data !== 23'h000029 || io_w.out_data !== 23'h000029) begin errs++; $display("FAIL basic_sum: got %h/%h want 000029", io_s.out_data, io_w.out_data); end
    checks++; if (ovf_s !== 1'b0 || busy_s !== 1'b1 || io_s.in_ready !== 1'b0) begin errs++; $display("FAIL basic_flags: got ovf=%b busy=%b ir=%b want 0 1 0", ovf_s, busy_s, io_s.in_ready); end
    checks++; if (count_s !== cnt_done) begin errs++; $display("FAIL basic_count: got %0d want %0d", count_s, cnt_done); end
    take_output();
    checks++; if (io_s.out_valid !== 1'b0 || busy_s !== 1'b0) begin errs++; $display("FAIL basic_handoff: got ov=%b busy=%b want 0 0", io_s.out_valid, busy_s); end
    checks++; if (io_s.out_data !== 23'h000029) begin errs++; $display("FAIL basic_hold_idle: got %h want 000029", io_s.out_data); end
  endtask

  task automatic test_zero_norm();
    logic [22:0] ops [N];
    int fv; bit to;
    for (int i = 0; i < N; i++) ops[i] = '0;
    ops[0] = {1'b1, 22'd3};
    drive_eval(23'd10, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== 23'd7) begin errs++; $display("FAIL signdiff_sum: got %h to=%b want 000007", io_s.out_data, to); end
    take_output();
    drive_eval(23'd3, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== 23'h000000 || io_w.out_data !== 23'h000000) begin errs++; $display("FAIL neg_zero_sum: got %h/%h want 000000", io_s.out_data, io_w.out_data); end
    take_output();
    ops[0] = '0;
    drive_eval({1'b1, 22'd0}, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== 23'h000000) begin errs++; $display("FAIL neg_zero_bias: got %h want 000000", io_s.out_data); end
    take_output();
  endtask

  task automatic test_overflow();
    logic [22:0] ops [N];
    int fv; bit to;
    for (int i = 0; i < N; i++) ops[i] = '0;
    ops[0] = 23'h20;
    drive_eval(23'h3FFFF0, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== 23'h3FFFFF || ovf_s !== 1'b1) begin errs++; $display("FAIL sat_overflow: got %h ovf=%b want 3fffff ovf=1", io_s.out_data, ovf_s); end
    checks++; if (io_w.out_data !== 23'h000010 || ovf_w !== 1'b1) begin errs++; $display("FAIL wrap_overflow: got %h ovf=%b want 000010 ovf=1", io_w.out_data, ovf_w); end
    take_output();
    checks++; if (ovf_s !== 1'b1) begin errs++; $display("FAIL ovf_sticky_idle: got %b want 1", ovf_s); end
    for (int i = 0; i < N; i++) ops[i] = 23'(i + 1);
    drive_eval(23'd5, ops, 0, 1'b0, fv, to);
    checks++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0 || io_s.out_data !== 23'h000029) begin errs++; $display("FAIL ovf_cleared_by_start: got ovf=%b/%b sum=%h want 0/0 000029", ovf_s, ovf_w, io_s.out_data); end
    take_output();
  endtask

  task automatic test_random_stall();
    logic [22:0] ops [N];
    logic [22:0] b, exp_s, exp_w;
    bit of_s, of_w, to;
    int fv;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        ops[i][22]   = 1'($urandom);
        ops[i][21:0] = ($urandom_range(0, 2) == 0) ? 22'(MAXM - $urandom_range(0, 2000))
                                                   : 22'($urandom_range(0, 65535));
      end
      b = 23'($urandom);
      model(b, ops, 1'b1, exp_s, of_s);
      model(b, ops, 1'b0, exp_w, of_w);
      drive_eval(b, ops, 40, 1'b1, fv, to);
      checks++; if (to || fv == 0) begin errs++; $display("FAIL rnd_done[%0d]: got to=%b first_valid=%0d want completion", it, to, fv); end
      checks++; if (io_s.out_data !== exp_s || ovf_s !== of_s) begin errs++; $display("FAIL rnd_sat[%0d]: got %h ovf=%b want %h ovf=%b", it, io_s.out_data, ovf_s, exp_s, of_s); end
      checks++; if (io_w.out_data !== exp_w || ovf_w !== of_w) begin errs++; $display("FAIL rnd_wrap[%0d]: got %h ovf=%b want %h ovf=%b", it, io_w.out_data, ovf_w, exp_w, of_w); end
      for (int k = 0; k < 5; k++) begin
        start = k[0];
        bias = 23'($urandom);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (io_s.out_valid !== 1'b1 || io_s.in_ready !== 1'b0 || io_s.out_data !== exp_s || count_s !== cnt_done) begin errs++; $display("FAIL rnd_stall[%0d.%0d]: got ov=%b ir=%b data=%h cnt=%0d want 1 0 %h %0d", it, k, io_s.out_valid, io_s.in_ready, io_s.out_data, count_s, exp_s, cnt_done); end
      end
      start = 1'b0;
      in_valid = 1'b0;
      take_output();
      checks++; if (io_s.out_valid !== 1'b0) begin errs++; $display("FAIL rnd_release[%0d]: got ov=%b want 0", it, io_s.out_valid); end
    end
  endtask

  task automatic test_clear();
    logic [22:0] ops [N];
    logic [22:0] prev, exp_s;
    bit of_s, to;
    int fv;
    prev = io_s.out_data;
    bias = 23'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 23'd7;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (count_s !== 3'd3) begin errs++; $display("FAIL clear_precount: got %0d want 3", count_s); end
    clear = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (io_s.in_ready !== 1'b0 || count_s !== '0 || busy_s !== 1'b0 || io_s.out_valid !== 1'b0) begin errs++; $display("FAIL clear_idle: got ir=%b cnt=%0d busy=%b ov=%b want 0 0 0 0", io_s.in_ready, count_s, busy_s, io_s.out_valid); end
    checks++; if (io_s.out_data !== prev) begin errs++; $display("FAIL clear_hold_data: got %h want %h", io_s.out_data, prev); end
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    checks++; if (busy_s !== 1'b0) begin errs++; $display("FAIL clear_beats_start: got busy=%b want 0", busy_s); end
    for (int i = 0; i < N; i++) ops[i] = {1'($urandom), 22'($urandom_range(0, 5000))};
    model(23'd1234, ops, 1'b1, exp_s, of_s);
    drive_eval(23'd1234, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== exp_s || fv !== 9) begin errs++; $display("FAIL clear_restart: got %h lat=%0d want %h lat=9", io_s.out_data, fv, exp_s); end
    take_output();
  endtask

  task automatic test_async_reset();
    logic [22:0] ops [N];
    logic [22:0] exp_s;
    bit of_s, to, seen;
    int fv;
    bias = 23'h3FFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 23'h3FFFFF;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (ovf_s !== 1'b1 || io_s.in_ready !== 1'b1) begin errs++; $display("FAIL prereset_state: got ovf=%b ir=%b want 1 1", ovf_s, io_s.in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({io_s.out_data, count_s, ovf_s, busy_s, io_s.in_ready, io_s.out_valid} !== '0) begin errs++; $display("FAIL async_reset: got data=%h cnt=%0d ovf=%b busy=%b ir=%b ov=%b want all 0", io_s.out_data, count_s, ovf_s, busy_s, io_s.in_ready, io_s.out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 23'd1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (io_s.out_valid || io_s.in_ready) seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (seen !== 1'b0) begin errs++; $display("FAIL no_start_no_output: got activity=%b want 0", seen); end
    for (int i = 0; i < N; i++) ops[i] = 23'(i * 3);
    model(23'd9, ops, 1'b1, exp_s, of_s);
    drive_eval(23'd9, ops, 0, 1'b0, fv, to);
    checks++; if (to || io_s.out_data !== exp_s) begin errs++; $display("FAIL post_reset_eval: got %h want %h", io_s.out_data, exp_s); end
    take_output();
  endtask

  initial begin
    cnt_done = CNT_W'(N);
    test_reset();
    test_basic_sum();
    test_zero_norm();
    test_overflow();
    test_random_stall();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
